pixel_write_buffer: RTL and testbench

- Sits directly downstream of the voxel_gpu shader array and upstream of the Avalon-MM interconnect to on-chip framebuffer RAM.
- Accepts shaded pixels as (row, col, colour) from the shaders and converts each to a framebuffer byte address.
- Buffers pixels in a FIFO and drains them as 16-bit Avalon master writes, honouring m1_waitrequest.
- Provides flush/done signalling so the GPU raises its interrupt only once every pixel of a chunk has landed in memory.

---
 rtl/pixel_write_buffer.sv | 139 +++++++++++++
 tb/tb_pixel_write_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// Shader pixel -> framebuffer write FIFO: push-to-m1_write latency 1 cycle when empty; px_ready drops only when full, outputs held under m1_waitrequest.
// Optional out-of-range pixel dropping with sticky bounds_err when PIXEL_BOUNDS_CHECK_EN is defined.
module pixel_write_buffer #(
  parameter logic [31:0] FB_BASE = 32'h0800_0000,
  parameter int          DEPTH   = 16,
  parameter int          H_RES   = 320,
  parameter int          V_RES   = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [7:0]  px_row,
  input  logic [8:0]  px_col,
  input  logic [15:0] px_color,
  input  logic        flush,
  output logic        done,
  output logic        busy,
  output logic [31:0] m1_address,
  output logic [15:0] m1_writedata,
  output logic        m1_write,
  input  logic        m1_waitrequest,
  output logic [15:0] stall_cycles,
  output logic        bounds_err
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   LP_DEPTH = (PW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      H_RES < 1 || H_RES > 512 || V_RES < 1 || V_RES > 256) begin : g_bad_params
    $error("pixel_write_buffer: illegal DEPTH/H_RES/V_RES");
  end

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  logic [47:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [15:0]   r_stall;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;
  logic          w_enq;
  logic          w_pop;
  logic [31:0]   w_addr;
  logic [47:0]   w_head;

  assign px_ready = reset && (r_count < LP_DEPTH);
  assign w_push   = px_valid && px_ready;
  assign w_pop    = m1_write && !m1_waitrequest;
  assign w_addr   = FB_BASE + {14'd0, px_row, px_col, 1'b0};

`ifdef PIXEL_BOUNDS_CHECK_EN
  localparam logic [9:0] LP_H = 10'(H_RES);
  localparam logic [8:0] LP_V = 9'(V_RES);
  logic w_in_range;
  logic r_bounds_err;

  assign w_in_range = ({1'b0, px_col} < LP_H) && ({1'b0, px_row} < LP_V);
  assign w_enq      = w_push && w_in_range;
  assign bounds_err = r_bounds_err;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bounds_err <= 1'b0;
    end else if (w_push && !w_in_range) begin
      r_bounds_err <= 1'b1;
    end
  end
`else
  assign w_enq      = w_push;
  assign bounds_err = 1'b0;
`endif

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= {w_addr, px_color};
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign m1_write     = (r_count != '0);
  assign m1_address   = m1_write ? w_head[47:16] : 32'd0;
  assign m1_writedata = m1_write ? w_head[15:0]  : 16'd0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stall <= 16'd0;
    end else if (m1_write && m1_waitrequest && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A push in the same cycle keeps DRAIN alive even if the FIFO just emptied.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (flush) w_state_nxt = S_DRAIN;
      S_DRAIN: if ((r_count == '0) && !w_push) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done = (r_state == S_DONE);
    busy = (r_count != '0) || (r_state != S_IDLE);
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer: expected writes queued at push, checked by a negedge monitor.
module tb_pixel_write_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [7:0]  px_row = '0;
  logic [8:0]  px_col = '0;
  logic [15:0] px_color = '0;
  logic        flush = 1'b0;
  logic        done;
  logic        busy;
  logic [31:0] m1_address;
  logic [15:0] m1_writedata;
  logic        m1_write;
  logic        m1_waitrequest = 1'b0;
  logic [15:0] stall_cycles;
  logic        bounds_err;

  always #5 clock = ~clock;

  pixel_write_buffer #(
    .FB_BASE(32'h0800_0000),
    .DEPTH  (16),
    .H_RES  (320),
    .V_RES  (240)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .px_valid      (px_valid),
    .px_ready      (px_ready),
    .px_row        (px_row),
    .px_col        (px_col),
    .px_color      (px_color),
    .flush         (flush),
    .done          (done),
    .busy          (busy),
    .m1_address    (m1_address),
    .m1_writedata  (m1_writedata),
    .m1_write      (m1_write),
    .m1_waitrequest(m1_waitrequest),
    .stall_cycles  (stall_cycles),
    .bounds_err    (bounds_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_pushed = 0;
  int          n_written = 0;
  int          cyc = 0;
  logic [47:0] exp_q[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [7:0] r, input logic [8:0] c);
    return 32'h0800_0000 + {14'd0, r, c, 1'b0};
  endfunction

  // Monitor: scoreboard pops, hold-stable check and a stall counter model.
  logic        prev_stall = 1'b0;
  logic        prev_rst_low = 1'b0;
  logic [48:0] prev_out = '0;
  logic [15:0] model_stall = '0;
  bit          stall_armed = 1'b0;

  always @(negedge clock) begin
    logic [47:0] e;
    if (prev_rst_low) begin
      model_stall = 16'd0;
      stall_armed = 1'b1;
    end else if (prev_stall && model_stall != 16'hFFFF) begin
      model_stall = model_stall + 16'd1;
    end
    if (stall_armed) chk("stall_cycles", 32'(stall_cycles), 32'(model_stall));
    if (prev_stall) chk("hold_stable", 32'({m1_write, m1_address, m1_writedata} === prev_out), 32'd1);
    if (reset === 1'b1 && m1_write === 1'b1 && m1_waitrequest === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", m1_address, m1_writedata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", m1_address, e[47:16]);
        chk("wr_data", 32'(m1_writedata), 32'(e[15:0]));
        n_written++;
      end
    end
    prev_rst_low = (reset === 1'b0);
    prev_stall   = (reset === 1'b1) && (m1_write === 1'b1) && (m1_waitrequest === 1'b1);
    prev_out     = {m1_write, m1_address, m1_writedata};
  end

  // Presents a pixel and returns 1 time unit after the accepting edge, px_valid left high.
  task automatic drive_px(input logic [7:0] r, input logic [8:0] c, input logic [15:0] d, input bit enq);
    int budget = 200;
    px_row = r; px_col = c; px_color = d; px_valid = 1'b1;
    while (1) begin
      @(negedge clock);
      if (px_ready === 1'b1) break;
      budget--;
      if (budget == 0) begin
        checks++;
        errors++;
        $display("FAIL px_ready_timeout: got px_ready=%b for 200 cycles, expected 1", px_ready);
        break;
      end
    end
    if (px_ready === 1'b1 && enq) begin
      exp_q.push_back({exp_addr(r, c), d});
      n_pushed++;
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_drained(input string name);
    int b = 0;
    @(negedge clock);
    while (busy !== 1'b0 && b < 300) begin
      @(negedge clock);
      b++;
    end
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int b;
    int early;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_px_ready", 32'(px_ready), 32'd0);
    chk("rst_m1_write", 32'(m1_write), 32'd0);
    chk("rst_m1_address", m1_address, 32'd0);
    chk("rst_m1_writedata", 32'(m1_writedata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_bounds_err", 32'(bounds_err), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_no_write", 32'(m1_write), 32'd0);
    chk("post_rst_ready", 32'(px_ready), 32'd1);

    // Single pixel, latency 1
    @(posedge clock); #1;
    drive_px(8'd1, 9'd2, 16'hF800, 1'b1);
    px_valid = 1'b0;
    @(negedge clock);
    chk("t1_write", 32'(m1_write), 32'd1);
    chk("t1_addr", m1_address, 32'h0800_0404);
    chk("t1_data", 32'(m1_writedata), 32'h0000_F800);
    @(negedge clock);
    chk("t1_write_drop", 32'(m1_write), 32'd0);

    // Fill to full under waitrequest
    @(posedge clock); #1;
    m1_waitrequest = 1'b1;
    for (int i = 0; i < 16; i++) drive_px(8'(i + 3), 9'(i * 17 + 5), 16'(16'h1000 + i), 1'b1);
    @(negedge clock);
    chk("t2_full_ready", 32'(px_ready), 32'd0);
    chk("t2_head_addr", m1_address, exp_addr(8'd3, 9'd5));
    chk("t2_head_data", 32'(m1_writedata), 32'h0000_1000);
    repeat (3) begin
      @(negedge clock);
      chk("t2_ready_held", 32'(px_ready), 32'd0);
    end

    // Release with a continuing stream: one write per cycle, nothing lost
    @(posedge clock); #1;
    m1_waitrequest = 1'b0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) drive_px(8'(100 + i), 9'(300 + i), 16'(16'hA000 + i), 1'b1);
    px_valid = 1'b0;
    b = 0;
    @(negedge clock);
    while (m1_write !== 1'b0 && b < 100) begin
      @(negedge clock);
      b++;
    end
    chk("t3_throughput", 32'(cyc - t0), 32'd24);
    chk("t3_count", 32'(n_written), 32'(n_pushed));
    @(posedge clock); #1;

    // Flush on empty FIFO
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    chk("t4_done_n1", 32'(done), 32'd0);
    chk("t4_busy_drain", 32'(busy), 32'd1);
    @(negedge clock);
    chk("t4_done_n2", 32'(done), 32'd1);
    @(negedge clock);
    chk("t4_done_n3", 32'(done), 32'd0);
    chk("t4_busy_idle", 32'(busy), 32'd0);

    // Flush with three queued pixels
    @(posedge clock); #1;
    m1_waitrequest = 1'b1;
    drive_px(8'd10, 9'd20, 16'h0001, 1'b1);
    drive_px(8'd11, 9'd21, 16'h0002, 1'b1);
    drive_px(8'd12, 9'd22, 16'h0003, 1'b1);
    px_valid = 1'b0;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    m1_waitrequest = 1'b0;
    b = 0;
    early = 0;
    @(negedge clock);
    while (m1_write !== 1'b0 && b < 50) begin
      if (done === 1'b1) early++;
      @(negedge clock);
      b++;
    end
    chk("t5_no_early_done", 32'(early), 32'd0);
    chk("t5_done_at_empty", 32'(done), 32'd0);
    @(negedge clock);
    chk("t5_done_pulse", 32'(done), 32'd1);
    @(negedge clock);
    chk("t5_done_clear", 32'(done), 32'd0);
    chk("t5_busy_idle", 32'(busy), 32'd0);

    // Reset mid-drain discards queued pixels and the pending flush
    @(posedge clock); #1;
    m1_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) drive_px(8'(50 + i), 9'(60 + i), 16'(16'h5500 + i), 1'b1);
    px_valid = 1'b0;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    n_pushed = n_written;
    @(posedge clock); #1;
    reset = 1'b1;
    m1_waitrequest = 1'b0;
    @(negedge clock);
    chk("t6_write", 32'(m1_write), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_stall", 32'(stall_cycles), 32'd0);
    repeat (3) begin
      chk("t6_no_done", 32'(done), 32'd0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    drive_px(8'd239, 9'd319, 16'h07E0, 1'b1);
    px_valid = 1'b0;
    wait_drained("t6_after");

`ifdef PIXEL_BOUNDS_CHECK_EN
    drive_px(8'd0, 9'd320, 16'hFFFF, 1'b0);
    px_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("t7_dropped_no_write", 32'(m1_write), 32'd0);
    end
    chk("t7_bounds_err_set", 32'(bounds_err), 32'd1);
    @(posedge clock); #1;
    drive_px(8'd2, 9'd5, 16'h001F, 1'b1);
    px_valid = 1'b0;
    wait_drained("t7_inrange");
    chk("t7_bounds_err_sticky", 32'(bounds_err), 32'd1);
`else
    drive_px(8'd0, 9'd320, 16'hFFFF, 1'b1);
    px_valid = 1'b0;
    wait_drained("t7_nocheck");
    chk("t7_bounds_err_zero", 32'(bounds_err), 32'd0);
`endif

    chk("total_writes", 32'(n_written), 32'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
